// File: rtl/lockable_reg_bank.sv
// Bank of lockable configuration registers with sticky per-entry and global
// locks, write-once option, rejected-write reporting and a registered read port.
module lockable_reg_bank #(
  parameter int              WIDTH      = 8,
  parameter int              DEPTH      = 4,
  parameter int              ADDR_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              WRITE_ONCE = 1'b0,
  parameter int              ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 lock_en,
  input  logic [ADDR_W-1:0]    lock_addr,
  input  logic                 lock_all,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic [DEPTH-1:0]     lock_status,
  output logic                 wr_ack,
  output logic                 wr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0]     r_lock;
  logic [WIDTH-1:0]     r_rd_data;
  logic                 r_ack;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_cnt;

  logic [DEPTH-1:0]     w_set;
  logic [DEPTH-1:0]     w_sel;
  logic [DEPTH-1:0]     w_once;
  logic [WIDTH-1:0]     w_rd;
  logic                 w_ok;
  logic                 w_rej;

  // Out-of-range addresses match no entry, so they decode to nothing.
  always_comb begin
    w_set = '0;
    w_sel = '0;
    w_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lock_all || (lock_en && lock_addr == ADDR_W'(i)))
        w_set[i] = 1'b1;
      if (wr_addr == ADDR_W'(i))
        w_sel[i] = 1'b1;
      if (rd_addr == ADDR_W'(i))
        w_rd = r_mem[i];
    end
  end

  // A same-cycle lock on the target beats the write.
  assign w_ok   = wr_en && (|w_sel) &&
                  ((w_sel & (r_lock | w_set)) == '0);
  assign w_rej  = wr_en && !w_ok;
  assign w_once = (WRITE_ONCE && w_ok) ? w_sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_ok && w_sel[i])
          r_mem[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= '0;
      r_rd_data <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_lock    <= r_lock | w_set | w_once;
      r_rd_data <= w_rd;
      r_ack     <= w_ok;
      r_err     <= w_rej;
      if (w_rej && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rd_data     = r_rd_data;
  assign lock_status = r_lock;
  assign wr_ack      = r_ack;
  assign wr_err      = r_err;
  assign err_count   = r_cnt;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Bench for lockable_reg_bank: three configurations (default, write-once,
// DEPTH=3) driven in parallel and compared against an array-based model.
module tb_lockable_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       lock_en = 1'b0;
  logic [1:0] lock_addr = '0;
  logic       lock_all = 1'b0;
  logic [1:0] rd_addr = '0;

  always #5 clk = ~clk;

  logic [7:0] rd0, rd1, rd2;
  logic [3:0] ls0, ls1;
  logic [2:0] ls2;
  logic       ack0, ack1, ack2, err0, err1, err2;
  logic [7:0] cnt0, cnt1, cnt2;

  lockable_reg_bank u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
    .lock_all(lock_all), .rd_addr(rd_addr), .rd_data(rd0),
    .lock_status(ls0), .wr_ack(ack0), .wr_err(err0), .err_count(cnt0));

  lockable_reg_bank #(.WRITE_ONCE(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
    .lock_all(lock_all), .rd_addr(rd_addr), .rd_data(rd1),
    .lock_status(ls1), .wr_ack(ack1), .wr_err(err1), .err_count(cnt1));

  lockable_reg_bank #(.DEPTH(3)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .lock_en(lock_en), .lock_addr(lock_addr),
    .lock_all(lock_all), .rd_addr(rd_addr), .rd_data(rd2),
    .lock_status(ls2), .wr_ack(ack2), .wr_err(err2), .err_count(cnt2));

  logic [7:0] o_rd [3];
  logic [3:0] o_ls [3];
  logic       o_ack[3];
  logic       o_err[3];
  logic [7:0] o_cnt[3];

  always_comb begin
    o_rd[0] = rd0;  o_rd[1] = rd1;  o_rd[2] = rd2;
    o_ls[0] = ls0;  o_ls[1] = ls1;  o_ls[2] = {1'b0, ls2};
    o_ack[0] = ack0; o_ack[1] = ack1; o_ack[2] = ack2;
    o_err[0] = err0; o_err[1] = err1; o_err[2] = err2;
    o_cnt[0] = cnt0; o_cnt[1] = cnt1; o_cnt[2] = cnt2;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays, rules applied per request.
  int         m_depth[3] = '{4, 4, 3};
  bit         m_wo[3]    = '{1'b0, 1'b1, 1'b0};
  logic [7:0] m_mem[3][4];
  logic [3:0] m_lock[3];
  int         m_cnt[3];
  logic [7:0] e_rd[3];
  logic       e_ack[3];
  logic       e_err[3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 4; a++) m_mem[d][a] = 8'h00;
      m_lock[d] = '0;
      m_cnt[d]  = 0;
      e_rd[d]   = 8'h00;
      e_ack[d]  = 1'b0;
      e_err[d]  = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; lock_en = 1'b0; lock_all = 1'b0;
  endtask

  // One clock with the current inputs; model predicts post-edge outputs.
  task automatic step();
    bit inr, ok;
    for (int d = 0; d < 3; d++) begin
      e_rd[d] = (rd_addr < m_depth[d]) ? m_mem[d][rd_addr] : 8'h00;
      inr = wr_addr < m_depth[d];
      ok  = wr_en && inr && !lock_all &&
            !(inr && m_lock[d][wr_addr]) &&
            !(lock_en && lock_addr == wr_addr);
      e_ack[d] = ok;
      e_err[d] = wr_en && !ok;
      if (ok) begin
        m_mem[d][wr_addr] = wr_data;
        if (m_wo[d]) m_lock[d][wr_addr] = 1'b1;
      end
      if (e_err[d] && m_cnt[d] < 255) m_cnt[d]++;
      for (int a = 0; a < m_depth[d]; a++)
        if (lock_all || (lock_en && lock_addr == a))
          m_lock[d][a] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({o_rd[d], o_ls[d], o_ack[d], o_err[d], o_cnt[d]} !== 22'h0) begin
          errors++;
          $display("FAIL reset d=%0d a=%0d got rd=%h ls=%b ack=%b err=%b cnt=%0d exp all 0",
                   d, a, o_rd[d], o_ls[d], o_ack[d], o_err[d], o_cnt[d]);
        end
      end
    end
  endtask

  task automatic test_basic_write();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; rd_addr = 2'd2;
    step();
    idle();
    checks++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || rd0 !== 8'h00) begin
      errors++;
      $display("FAIL basic_ack got ack=%b err=%b rd=%h exp 1 0 00", ack0, err0, rd0);
    end
    step();
    checks++;
    if (rd0 !== 8'hA5 || ack0 !== 1'b0 || ls0 !== 4'b0) begin
      errors++;
      $display("FAIL basic_read got rd=%h ack=%b ls=%b exp a5 0 0000", rd0, ack0, ls0);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_rd[d], o_ls[d], o_ack[d], o_err[d], o_cnt[d]} !==
          {e_rd[d], m_lock[d], e_ack[d], e_err[d], 8'(m_cnt[d])}) begin
        errors++;
        $display("FAIL basic_model d=%0d got rd=%h ls=%b cnt=%0d exp rd=%h ls=%b cnt=%0d",
                 d, o_rd[d], o_ls[d], o_cnt[d], e_rd[d], m_lock[d], m_cnt[d]);
      end
    end
  endtask

  task automatic test_lock();
    lock_en = 1'b1; lock_addr = 2'd1;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
    step();
    idle();
    checks++;
    if (ls0 !== 4'b0010 || err0 !== 1'b1 || ack0 !== 1'b0 || cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL lock_reject got ls=%b err=%b ack=%b cnt=%0d exp 0010 1 0 1",
               ls0, err0, ack0, cnt0);
    end
    rd_addr = 2'd1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h5A;
    step();
    idle();
    checks++;
    if (rd0 !== 8'h00 || ack0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL lock_other got rd=%h ack=%b err=%b exp 00 1 0", rd0, ack0, err0);
    end
  endtask

  task automatic test_same_cycle();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'hFF;
    lock_en = 1'b1; lock_addr = 2'd3; rd_addr = 2'd3;
    step();
    idle();
    step();
    checks++;
    if (ls0[3] !== 1'b1 || cnt0 !== 8'd2 || rd0 !== 8'h00) begin
      errors++;
      $display("FAIL same_cycle got ls=%b cnt=%0d rd=%h exp 1xxx 2 00", ls0, cnt0, rd0);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({o_rd[d], o_ls[d], o_cnt[d]} !== {e_rd[d], m_lock[d], 8'(m_cnt[d])}) begin
        errors++;
        $display("FAIL same_model d=%0d got rd=%h ls=%b cnt=%0d exp rd=%h ls=%b cnt=%0d",
                 d, o_rd[d], o_ls[d], o_cnt[d], e_rd[d], m_lock[d], m_cnt[d]);
      end
    end
  endtask

  task automatic test_write_once();
    do_reset();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h11; rd_addr = 2'd0;
    step();
    checks++;
    if (ack1 !== 1'b1 || ls1 !== 4'b0001) begin
      errors++;
      $display("FAIL wo_first got ack=%b ls=%b exp 1 0001", ack1, ls1);
    end
    wr_data = 8'h22;
    step();
    idle();
    checks++;
    if (err1 !== 1'b1 || ack1 !== 1'b0 || cnt1 !== 8'd1 || ack0 !== 1'b1) begin
      errors++;
      $display("FAIL wo_second got err=%b ack=%b cnt=%0d ack0=%b exp 1 0 1 1",
               err1, ack1, cnt1, ack0);
    end
    step();
    checks++;
    if (rd1 !== 8'h11 || rd0 !== 8'h22) begin
      errors++;
      $display("FAIL wo_read got rd1=%h rd0=%h exp 11 22", rd1, rd0);
    end
  endtask

  task automatic test_saturate_and_reset();
    lock_all = 1'b1;
    step();
    idle();
    for (int n = 0; n < 259; n++) begin
      wr_en = 1'b1; wr_addr = 2'($urandom); wr_data = 8'($urandom);
      rd_addr = 2'($urandom);
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({o_rd[d], o_ack[d], o_err[d], o_cnt[d]} !==
            {e_rd[d], 1'b0, 1'b1, 8'(m_cnt[d])}) begin
          errors++;
          $display("FAIL sat n=%0d d=%0d got rd=%h ack=%b err=%b cnt=%0d exp rd=%h 0 1 %0d",
                   n, d, o_rd[d], o_ack[d], o_err[d], o_cnt[d], e_rd[d], m_cnt[d]);
        end
      end
    end
    checks++;
    if (cnt0 !== 8'hFF || cnt1 !== 8'hFF || ls0 !== 4'hF || ls2 !== 3'b111) begin
      errors++;
      $display("FAIL sat_final got cnt0=%h cnt1=%h ls0=%b ls2=%b exp ff ff 1111 111",
               cnt0, cnt1, ls0, ls2);
    end
    // In-flight request when reset strikes mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd0, ls0, ack0, err0, cnt0} !== 22'h0 || ls2 !== 3'b0) begin
      errors++;
      $display("FAIL midreset got rd=%h ls=%b ack=%b err=%b cnt=%0d exp all 0",
               rd0, ls0, ack0, err0, cnt0);
    end
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77; rd_addr = 2'd1;
    step();
    idle();
    step();
    checks++;
    if (ack0 !== 1'b0 || rd0 !== 8'h77 || ls0 !== 4'b0 || cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL postreset got ack=%b rd=%h ls=%b cnt=%0d exp 0 77 0000 0",
               ack0, rd0, ls0, cnt0);
    end
  endtask

  task automatic test_depth3();
    do_reset();
    lock_en = 1'b1; lock_addr = 2'd3;
    step();
    idle();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h99; rd_addr = 2'd3;
    step();
    idle();
    checks++;
    if (err2 !== 1'b1 || ack2 !== 1'b0 || ls2 !== 3'b000 || rd2 !== 8'h00 || cnt2 !== 8'd1) begin
      errors++;
      $display("FAIL depth3 got err=%b ack=%b ls=%b rd=%h cnt=%0d exp 1 0 000 00 1",
               err2, ack2, ls2, rd2, cnt2);
    end
    checks++;
    if (ls0 !== 4'b1000 || err0 !== 1'b1) begin
      errors++;
      $display("FAIL depth4_lock3 got ls=%b err=%b exp 1000 1", ls0, err0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) do_reset();
      wr_en     = ($urandom_range(0, 3) != 0);
      wr_addr   = 2'($urandom);
      wr_data   = 8'($urandom);
      lock_en   = ($urandom_range(0, 15) == 0);
      lock_addr = 2'($urandom);
      lock_all  = ($urandom_range(0, 63) == 0);
      rd_addr   = 2'($urandom);
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({o_rd[d], o_ls[d], o_ack[d], o_err[d], o_cnt[d]} !==
            {e_rd[d], m_lock[d], e_ack[d], e_err[d], 8'(m_cnt[d])}) begin
          errors++;
          $display("FAIL random n=%0d d=%0d got rd=%h ls=%b ack=%b err=%b cnt=%0d exp rd=%h ls=%b ack=%b err=%b cnt=%0d",
                   n, d, o_rd[d], o_ls[d], o_ack[d], o_err[d], o_cnt[d],
                   e_rd[d], m_lock[d], e_ack[d], e_err[d], m_cnt[d]);
        end
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_basic_write();
    test_lock();
    test_same_cycle();
    test_write_once();
    test_saturate_and_reset();
    test_depth3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lockable_reg_bank.md
# lockable_reg_bank

Parametrised bank of DEPTH lockable configuration registers, each WIDTH bits, with per-register and global sticky locks that clear only on reset. It is the multi-entry successor to the single lockable register and sits behind the configuration write port of security-relevant blocks. It adds an optional write-once mode, rejected-write reporting, a saturating violation counter and a registered read port.

## Interface
- WIDTH, 8, data width of each register
- DEPTH, 4, number of registers; 1..2^ADDR_W
- ADDR_W, 2, address width
- RESET_VAL, 0, reset value of every register (WIDTH bits)
- WRITE_ONCE, 0, 1 = a register auto-locks on its first accepted write
- ERR_CNT_W, 8, width of the violation counter

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  write request, single-cycle qualifier
- wr_addr  in  ADDR_W  write target
- wr_data  in  WIDTH  write data
- lock_en  in  1  lock register lock_addr
- lock_addr  in  ADDR_W  lock target
- lock_all  in  1  lock every register
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  registered read data
- lock_status  out  DEPTH  bit i = register i locked
- wr_ack  out  1  one-cycle pulse: previous-cycle write accepted
- wr_err  out  1  one-cycle pulse: previous-cycle write rejected
- err_count  out  ERR_CNT_W  count of rejected writes, saturating

## Operation
- Reset (async assert, synchronous-release usage): all registers = RESET_VAL, lock_status = 0, rd_data = 0, wr_ack = 0, wr_err = 0, err_count = 0.
- Lock is sticky: once a lock bit is set, only rst_n clears it. No unlock path exists.
- lock_en sets bit lock_addr; lock_addr >= DEPTH is ignored. lock_all sets all bits. Both may be asserted together.
- A write is accepted when wr_en = 1, wr_addr < DEPTH, and the target is not locked, and no lock (lock_en to the same address, or lock_all) is asserted in the same cycle. Locks have priority over writes in the same cycle.
- An accepted write updates register wr_addr with wr_data at the edge. WRITE_ONCE = 1: the lock bit of that register is set at the same edge.
- A rejected write (locked target, same-cycle lock, or wr_addr >= DEPTH) leaves all registers unchanged and increments err_count by 1, holding at 2^ERR_CNT_W-1.
- wr_en = 0: no ack, no err, no count change.
- Read: rd_data <= register rd_addr each cycle; rd_addr >= DEPTH yields 0. Reads are never blocked by locks.

## Timing
- Write to register: visible in storage at the edge of wr_en; on rd_data one cycle later if rd_addr targets it.
- Same-cycle read and write to one address: rd_data returns the old value (read-before-write).
- Lock latency: lock_status bit set one edge after lock_en/lock_all. A write in the cycle after that edge is rejected.
- wr_ack / wr_err: registered, asserted exactly one cycle after the request edge, mutually exclusive, high for one cycle per request. Back-to-back requests produce back-to-back pulses.
- err_count updates at the request edge, concurrent with wr_err.
- Reset mid-operation: all outputs return to reset values immediately on rst_n falling; an in-flight request yields no ack/err.

## Test plan
- Reset, write 0xA5 to addr 2, read addr 2 -> wr_ack pulse next cycle, rd_data = 0xA5; other addresses read RESET_VAL; lock_status = 0.
- lock_en addr 1, then write 0x3C to addr 1 -> lock_status = 4'b0010, wr_err pulse, err_count = 1, addr 1 unchanged; write to addr 0 still acks.
- Same cycle: wr_en addr 3 data 0xFF with lock_en addr 3 -> write rejected, wr_err, lock_status[3] = 1, addr 3 keeps old value.
- WRITE_ONCE = 1: write 0x11 then 0x22 to addr 0 -> first acks, lock_status[0] = 1, second errs, readback 0x11.
- lock_all then 2^ERR_CNT_W + 3 writes -> every write errs, err_count saturates at all ones; assert rst_n low -> locks, counter, registers return to reset values and writes ack again.
- DEPTH = 3, ADDR_W = 2: write and lock addr 3 -> write errs, lock ignored, rd_addr 3 returns 0.
